// File: rtl/serial_compare4.sv
// Nibble-serial magnitude comparator: operands arrive MSB nibble first, one pair per beat,
// and the gt/lt decision is carried across beats in a registered one-hot code.
module serial_compare4 #(
    parameter int WORDS = 2,
    parameter int CW    = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iClear,
    input  logic       iValid,
    output logic       oReady,
    input  logic [3:0] iData_a,
    input  logic [3:0] iData_b,
    output logic       oValid,
    input  logic       iReady,
    output logic [2:0] oData,
    output logic       oBusy
);

    localparam logic [2:0]    CODE_GT = 3'b100;
    localparam logic [2:0]    CODE_LT = 3'b010;
    localparam logic [2:0]    CODE_EQ = 3'b001;
    localparam logic [CW-1:0] LAST    = CW'(WORDS - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dec_q, dec_d;
    logic          valid_q, valid_d;
    logic [2:0]    data_q, data_d;

    logic          accept;
    logic [2:0]    dec_nib;

    // Once a nibble differs the decision is final; lower nibbles only advance the count.
    always_comb begin
        dec_nib = dec_q;
        if (dec_q == CODE_EQ) begin
            if (iData_a > iData_b)      dec_nib = CODE_GT;
            else if (iData_a < iData_b) dec_nib = CODE_LT;
        end
    end

    assign oReady = (state_q == S_RUN);
    assign accept = iValid && oReady;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (iClear) begin
            state_d = S_RUN;
            cnt_d   = '0;
            dec_d   = CODE_EQ;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            state_d = S_DONE;
                            valid_d = 1'b1;
                            data_d  = dec_nib;
                            cnt_d   = '0;
                            dec_d   = CODE_EQ;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            dec_d = dec_nib;
                        end
                    end
                end
                S_DONE: begin
                    if (valid_q && iReady) begin
                        state_d = S_RUN;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            dec_q   <= CODE_EQ;
            valid_q <= 1'b0;
            data_q  <= CODE_EQ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // oData keeps the last presented result outside S_DONE; consumers qualify it with oValid.
    assign oValid = valid_q;
    assign oData  = data_q;
    assign oBusy  = (state_q == S_RUN) && (cnt_q != '0);

endmodule

// File: tb/tb_serial_compare4.sv
// Randomized + directed bench for serial_compare4; expected codes come from whole-word compares.
module tb_serial_compare4;

    logic       iClk, iRst, iClear, iValid, iReady;
    logic [3:0] iData_a, iData_b;
    logic       r2, v2, b2, r4, v4, b4;
    logic [2:0] d2, d4;
    logic       sel4;
    logic       oReady, oValid, oBusy;
    logic [2:0] oData;
    int         n_cmp, n_err;

    serial_compare4 #(.WORDS(2), .CW(4)) u_dut2 (
        .iClk(iClk), .iRst(iRst), .iClear(iClear), .iValid(iValid), .oReady(r2),
        .iData_a(iData_a), .iData_b(iData_b), .oValid(v2), .iReady(iReady),
        .oData(d2), .oBusy(b2)
    );

    serial_compare4 #(.WORDS(4), .CW(4)) u_dut4 (
        .iClk(iClk), .iRst(iRst), .iClear(iClear), .iValid(iValid), .oReady(r4),
        .iData_a(iData_a), .iData_b(iData_b), .oValid(v4), .iReady(iReady),
        .oData(d4), .oBusy(b4)
    );

    assign oReady = sel4 ? r4 : r2;
    assign oValid = sel4 ? v4 : v2;
    assign oBusy  = sel4 ? b4 : b2;
    assign oData  = sel4 ? d4 : d2;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [2:0] ref_code(input int nw, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, am, bm;
        m  = (nw >= 16) ? '1 : ((64'h1 << (nw * 4)) - 64'h1);
        am = a & m;
        bm = b & m;
        if (am > bm)      return 3'b100;
        else if (am < bm) return 3'b010;
        else              return 3'b001;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst = 1'b1; iClear = 1'b0; iValid = 1'b0; iReady = 1'b0;
        tick();
        iRst = 1'b0;
    endtask

    // Feeds one operation, checks handshake/busy/result timing, then drains it after `hold` stalls.
    task automatic run_op(input string name, input int nw, input logic [63:0] a, input logic [63:0] b,
                          input int gapmax, input int hold);
        logic [2:0] exp;
        exp = ref_code(nw, a, b);
        for (int i = nw - 1; i >= 0; i--) begin
            int gaps;
            gaps = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            for (int g = 0; g < gaps; g++) begin
                iValid = 1'b0;
                iData_a = 4'($urandom); iData_b = 4'($urandom);
                tick();
                n_cmp++;
                if (oValid !== 1'b0 || oBusy !== (i != nw - 1)) begin
                    n_err++;
                    $display("FAIL %s gap: oValid=%b oBusy=%b required 0/%b", name, oValid, oBusy, (i != nw - 1));
                end
            end
            iValid = 1'b1;
            iData_a = a[i*4 +: 4];
            iData_b = b[i*4 +: 4];
            #1;
            n_cmp++;
            if (oReady !== 1'b1 || oValid !== 1'b0 || oBusy !== (i != nw - 1)) begin
                n_err++;
                $display("FAIL %s nibble%0d: oReady=%b oValid=%b oBusy=%b required 1/0/%b",
                         name, i, oReady, oValid, oBusy, (i != nw - 1));
            end
            tick();
        end
        iValid = 1'b0;
        n_cmp++;
        if (oValid !== 1'b1 || oData !== exp || oBusy !== 1'b0 || oReady !== 1'b0) begin
            n_err++;
            $display("FAIL %s result: oValid=%b oData=%b oBusy=%b oReady=%b required 1/%b/0/0",
                     name, oValid, oData, oBusy, oReady, exp);
        end
        for (int h = 0; h < hold; h++) begin
            iValid = 1'b1;
            iData_a = 4'($urandom); iData_b = 4'($urandom);
            tick();
            n_cmp++;
            if (oValid !== 1'b1 || oData !== exp || oReady !== 1'b0) begin
                n_err++;
                $display("FAIL %s hold%0d: oValid=%b oData=%b oReady=%b required 1/%b/0",
                         name, h, oValid, oData, oReady, exp);
            end
        end
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        iValid = 1'b0;
        n_cmp++;
        if (oValid !== 1'b0 || oReady !== 1'b1 || oBusy !== 1'b0 || oData !== exp) begin
            n_err++;
            $display("FAIL %s drain: oValid=%b oReady=%b oBusy=%b oData=%b required 0/1/0/%b",
                     name, oValid, oReady, oBusy, oData, exp);
        end
    endtask

    task automatic test_reset();
        sel4 = 1'b0;
        do_reset();
        n_cmp++;
        if (oValid !== 1'b0 || oData !== 3'b001 || oBusy !== 1'b0 || oReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset: oValid=%b oData=%b oBusy=%b oReady=%b required 0/001/0/1",
                     oValid, oData, oBusy, oReady);
        end
    endtask

    task automatic test_directed();
        run_op("a5_3c", 2, 64'hA5, 64'h3C, 0, 0);
        run_op("37_38", 2, 64'h37, 64'h38, 0, 0);
        run_op("5a_5a", 2, 64'h5A, 64'h5A, 0, 0);
        run_op("29_81", 2, 64'h29, 64'h81, 1, 0);
    endtask

    task automatic test_backpressure();
        run_op("stall5", 2, 64'hC3, 64'hC1, 0, 5);
    endtask

    task automatic test_clear();
        // first nibble of F0 vs 00 decides gt, then flush with a nibble offered in the same cycle
        iValid = 1'b1; iData_a = 4'hF; iData_b = 4'h0;
        tick();
        iClear = 1'b1; iData_a = 4'hF; iData_b = 4'h0;
        tick();
        iClear = 1'b0; iValid = 1'b0;
        n_cmp++;
        if (oBusy !== 1'b0 || oValid !== 1'b0 || oReady !== 1'b1) begin
            n_err++;
            $display("FAIL clear_run: oBusy=%b oValid=%b oReady=%b required 0/0/1", oBusy, oValid, oReady);
        end
        run_op("after_clear", 2, 64'h12, 64'h12, 0, 0);
        // a result held in S_DONE is discarded by iClear
        iValid = 1'b1; iData_a = 4'h9; iData_b = 4'h1;
        tick();
        tick();
        iValid = 1'b0;
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        n_cmp++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            n_err++;
            $display("FAIL clear_done: oValid=%b oReady=%b required 0/1", oValid, oReady);
        end
        run_op("after_clear2", 2, 64'h40, 64'h41, 0, 0);
    endtask

    task automatic test_midop_reset();
        iValid = 1'b1; iData_a = 4'hF; iData_b = 4'h0;
        tick();
        iValid = 1'b0;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        n_cmp++;
        if (oBusy !== 1'b0 || oValid !== 1'b0 || oData !== 3'b001) begin
            n_err++;
            $display("FAIL midop_reset: oBusy=%b oValid=%b oData=%b required 0/0/001", oBusy, oValid, oData);
        end
        run_op("after_reset", 2, 64'h12, 64'h12, 0, 0);
    endtask

    task automatic test_words4();
        sel4 = 1'b1;
        do_reset();
        run_op("w4_toggle", 4, 64'h1234, 64'h1235, 1, 0);
        run_op("w4_gt", 4, 64'h8000, 64'h7FFF, 0, 2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            logic [63:0] a, b;
            a = {32'h0, $urandom};
            b = (k % 3 == 0) ? a : {32'h0, $urandom};
            run_op("b2b", sel4 ? 4 : 2, a, b, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 2; w++) begin
            sel4 = (w == 1);
            do_reset();
            for (int k = 0; k < 25; k++) begin
                logic [63:0] a, b;
                int sel;
                a = {32'h0, $urandom};
                sel = $urandom_range(3, 0);
                // bias toward shared prefixes so low nibbles get to decide
                if (sel == 0)      b = a;
                else if (sel == 1) b = {a[63:4], 4'($urandom)};
                else               b = {32'h0, $urandom};
                run_op("rand", sel4 ? 4 : 2, a, b, 2, $urandom_range(3, 0));
            end
            test_back_to_back();
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        iRst = 1'b0; iClear = 1'b0; iValid = 1'b0; iReady = 1'b0;
        iData_a = 4'h0; iData_b = 4'h0; sel4 = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_clear();
        test_midop_reset();
        test_back_to_back();
        test_words4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_compare4.md
Name: serial_compare4

Overview:
- Time-multiplexed magnitude comparator that takes two operands of WORDS nibbles each, one nibble pair per accepted beat, most significant nibble first.
- Produces the team's one-hot compare code: 3'b100 when a>b, 3'b010 when a<b, 3'b001 when a==b.
- The gt/lt decision carries across cycles through a registered state, instead of through a chain of comparator stages.
- Sits between a nibble-serial operand source and any consumer of the compare code; valid/ready handshakes on both sides.

Parameters:
- WORDS, 2, number of 4-bit nibbles per operand; default 2 gives an 8-bit compare; legal range 1..16.
- CW, 4, width of the internal nibble counter; must satisfy 2^CW >= WORDS.

Ports:
- iClk  input  1  rising-edge clock.
- iRst  input  1  synchronous, active-high reset.
- iClear  input  1  synchronous flush of the operation in progress; returns the block to nibble 0.
- iValid  input  1  iData_a and iData_b hold a valid nibble pair.
- oReady  output  1  the block accepts a nibble pair this cycle.
- iData_a  input  4  nibble of operand a.
- iData_b  input  4  nibble of operand b.
- oValid  output  1  oData holds a valid result.
- iReady  input  1  the consumer accepts the result.
- oData  output  3  one-hot compare code: 100 = gt, 010 = lt, 001 = eq.
- oBusy  output  1  at least one nibble of the current operation has been accepted and the result is not yet presented.

Behaviour:
- Reset: iRst high at a clock edge sets state=S_RUN, cnt=0, dec=3'b001, oValid=0, oData=3'b001, oBusy=0. iRst has priority over every other input.
- oReady=1 exactly when state==S_RUN; it is decoded from state only.
- Accept = iValid && oReady.
- States:
  - S_RUN: accepts nibble pairs.
  - S_DONE: holds the result.
- Per accepted nibble in S_RUN:
  - dec==001 and a>b (unsigned 4-bit compare): dec<=100.
  - dec==001 and a<b: dec<=010.
  - dec==001 and a==b: dec unchanged.
  - dec==100 or 010: dec is frozen; later nibbles are still consumed but ignored.
  - cnt<=cnt+1.
- Last nibble (accept while cnt==WORDS-1):
  - Next edge: state<=S_DONE, oValid<=1, oData<=final dec (this nibble included), cnt<=0, dec<=001.
  - Latency is 1 cycle from last-nibble accept to oValid.
- S_DONE:
  - oData and oValid hold stable until oValid && iReady.
  - That handshake edge sets oValid<=0 and state<=S_RUN.
  - No nibble is accepted in the handshake cycle, because oReady=0 there.
  - Minimum throughput: one operation per WORDS+1 cycles.
- oData outside S_DONE: keeps the last presented result (reset value 001). Consumers qualify oData with oValid.
- oBusy = (state==S_RUN) && (cnt!=0).
- iClear (when iRst is low):
  - Sets cnt=0, dec=001, state=S_RUN, oValid=0.
  - Any nibble offered in the same cycle is dropped.
  - A result held in S_DONE is discarded.
- iValid low in S_RUN: no state change; gaps between nibbles of any length are legal.
- WORDS==1: every accept is the last nibble.
- cnt wraps only through the last-nibble rule; it never reaches WORDS.
- Mid-operation reset: the partial compare is lost and the next accepted nibble is treated as the MSB nibble of a new operation.

Test Plan:
- Reset, then WORDS=2, a=8'hA5, b=8'h3C, nibbles fed back-to-back -> oValid=1 one cycle after the 2nd accept, oData=100, oBusy=1 only between the two accepts.
- a=8'h37, b=8'h38 -> oData=010, decided on the low nibble. Then a=8'h5A, b=8'h5A -> oData=001.
- a=8'h29, b=8'h81 -> the high nibble decides lt; a low-nibble a>b does not change the result; oData=010.
- Result presented, iReady held low 5 cycles while iValid=1 -> oReady=0 and oData stable throughout; iReady=1 -> oValid falls next cycle, oReady=1.
- Assert iClear after the first nibble of a=8'hF0, b=8'h00, then send a=8'h12, b=8'h12 -> oData=001 (the stale gt is discarded). Repeat with iRst mid-operation -> same outcome.
- WORDS=4, iValid toggling 1-0-1-0, a=16'h1234, b=16'h1235 -> oValid exactly once after the 4th accept, oData=010.
